// File: rtl/euler_result_tx.sv
// Captures a solver's final answer (or failure) and reports it over an 8N1 UART
// as unsigned decimal ASCII followed by CR LF, or "ERR" CR LF on failure.
module euler_result_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic        done,
  input  logic        error,
  output logic        tx,
  output logic        busy,
  output logic        sent
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SKIP,
    LOAD,
    START,
    DATA,
    STOP,
    FINISH
  } state_t;

  state_t state, state_next;

  logic          done_q, error_q;
  logic          done_rise, error_rise, accept;
  logic [31:0]   bin;
  logic [39:0]   bcd, bcd_adj;
  logic [71:0]   dd_next;
  logic [4:0]    conv_cnt;
  logic [3:0]    ptr, digit;
  logic [1:0]    stage;
  logic          err_mode, last_char;
  logic [7:0]    cur_char, tx_shift;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          baud_end, load_now, skip_zero, tx_next;

  assign done_rise  = done & ~done_q;
  assign error_rise = error & ~error_q;
  assign accept     = (state == IDLE) || (state == FINISH);
  assign baud_end   = (baud_cnt == BAUD_MAX);
  assign skip_zero  = (digit == 4'd0) && (ptr != 4'd0);
  assign load_now   = (state == LOAD) || ((state == STOP) && baud_end && !last_char);
  assign busy       = !accept;
  assign sent       = (state == FINISH);

  // Double-dabble step: correct every BCD digit, then shift the pair left by one.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    dd_next = {bcd_adj, bin} << 1;
  end

  always_comb begin
    digit = bcd[3:0];
    for (int i = 1; i < 10; i++) begin
      if (ptr == 4'(i))
        digit = bcd[i*4 +: 4];
    end
  end

  // Character under the pointer; stage 0 is the body, stages 1 and 2 are CR and LF.
  always_comb begin
    cur_char = 8'h0A;
    case (stage)
      2'd0:    cur_char = err_mode ? ((ptr == 4'd2) ? 8'h45 : 8'h52) : {4'h3, digit};
      2'd1:    cur_char = 8'h0D;
      default: cur_char = 8'h0A;
    endcase
  end

  always_comb begin
    state_next = state;
    tx_next    = tx;
    case (state)
      IDLE, FINISH: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        if (error_rise)
          state_next = LOAD;
        else if (done_rise)
          state_next = CONVERT;
      end
      CONVERT: begin
        if (conv_cnt == 5'd31)
          state_next = SKIP;
      end
      SKIP: begin
        if (!skip_zero)
          state_next = LOAD;
      end
      LOAD: begin
        state_next = START;
        tx_next    = 1'b0;
      end
      START: begin
        if (baud_end) begin
          state_next = DATA;
          tx_next    = tx_shift[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = tx_shift[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (last_char) begin
            state_next = FINISH;
            tx_next    = 1'b1;
          end else begin
            state_next = START;
            tx_next    = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state   <= state_next;
      tx      <= tx_next;
      done_q  <= done;
      error_q <= error;
    end
  end

  // Datapath: capture, conversion, leading-zero skip and the per-character shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin       <= '0;
      bcd       <= '0;
      conv_cnt  <= '0;
      ptr       <= '0;
      stage     <= '0;
      err_mode  <= 1'b0;
      last_char <= 1'b0;
      tx_shift  <= '0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (error_rise) begin
            err_mode <= 1'b1;
            ptr      <= 4'd2;
            stage    <= 2'd0;
          end else if (done_rise) begin
            err_mode <= 1'b0;
            bin      <= result;
            bcd      <= '0;
            conv_cnt <= '0;
            ptr      <= 4'd9;
            stage    <= 2'd0;
          end
        end
        CONVERT: begin
          bcd      <= dd_next[71:32];
          bin      <= dd_next[31:0];
          conv_cnt <= conv_cnt + 5'd1;
        end
        SKIP: begin
          if (skip_zero)
            ptr <= ptr - 4'd1;
        end
        START: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_end)
            bit_idx <= 3'd0;
        end
        DATA: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
          if (baud_end) begin
            bit_idx  <= bit_idx + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
          end
        end
        STOP: begin
          baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
        end
        default: begin
        end
      endcase

      if (load_now) begin
        tx_shift  <= cur_char;
        last_char <= (stage == 2'd2);
        baud_cnt  <= '0;
        if (stage == 2'd0) begin
          if (ptr == 4'd0)
            stage <= 2'd1;
          else
            ptr <= ptr - 4'd1;
        end else if (stage == 2'd1) begin
          stage <= 2'd2;
        end
      end
    end
  end

endmodule

// File: tb/tb_euler_result_tx.sv
// Randomised scoreboard bench: a decimal-string model feeds expected bytes and
// timings; a negedge UART receiver pops and compares as characters arrive.
module tb_euler_result_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0;
  logic        done = 1'b0;
  logic        error = 1'b0;
  logic        tx, busy, sent;

  euler_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .result(result), .done(done), .error(error),
    .tx(tx), .busy(busy), .sent(sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  byte unsigned exp_bytes[$];
  int           exp_start[$];
  int           exp_len[$];

  int       sent_cnt = 0;
  bit       rx_active = 1'b0;
  int       rx_cnt = 0;
  logic [9:0] rx_bits = '0;
  logic     bit_first = 1'b0;
  logic     prev_tx = 1'b1;
  bit       in_msg = 1'b0;
  int       msg_start = 0;
  int       msg_bytes = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Receiver and scoreboard consumer, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      in_msg    = 1'b0;
      prev_tx   = 1'b1;
      msg_bytes = 0;
    end else begin
      if (sent) begin
        sent_cnt++;
        checkOutput("sent_pending", int'(exp_len.size() > 0), 1);
        if (exp_len.size() > 0) begin
          int n;
          n = exp_len.pop_front();
          checkOutput("sent_timing", cyc - msg_start, n * 10 * CPB);
          checkOutput("msg_byte_count", msg_bytes, n);
        end
        checkOutput("bytes_left_at_sent", exp_bytes.size(), 0);
        checkOutput("busy_at_sent", int'(busy), 0);
        in_msg    = 1'b0;
        msg_bytes = 0;
      end
      if (!rx_active && prev_tx && !tx) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        if (!in_msg) begin
          in_msg    = 1'b1;
          msg_start = cyc;
          checkOutput("start_expected", int'(exp_start.size() > 0), 1);
          if (exp_start.size() > 0)
            checkOutput("first_start_edge", cyc, exp_start.pop_front());
        end
      end
      if (rx_active) begin
        int phase, bitn;
        phase = rx_cnt % CPB;
        bitn  = rx_cnt / CPB;
        if (phase == 0)
          bit_first = tx;
        else
          checkOutput("bit_width", int'(tx), int'(bit_first));
        if (phase == CPB / 2)
          rx_bits[bitn] = tx;
        rx_cnt++;
        if (rx_cnt == 10 * CPB) begin
          rx_active = 1'b0;
          checkOutput("start_bit", int'(rx_bits[0]), 0);
          checkOutput("stop_bit", int'(rx_bits[9]), 1);
          checkOutput("byte_expected", int'(exp_bytes.size() > 0), 1);
          if (exp_bytes.size() > 0)
            checkOutput("byte", int'(rx_bits[8:1]), int'(exp_bytes.pop_front()));
          msg_bytes++;
        end
      end
      prev_tx = tx;
    end
  end

  // Issue one capture and record what the line must carry for it.
  task automatic applyStimulus(input logic [31:0] value, input bit use_err, input bit also_done);
    string s;
    int    e;
    if (use_err) s = "ERR";
    else         s = $sformatf("%0d", value);
    for (int i = 0; i < s.len(); i++) exp_bytes.push_back(s[i]);
    exp_bytes.push_back(8'h0D);
    exp_bytes.push_back(8'h0A);
    exp_len.push_back(s.len() + 2);
    @(posedge clk); #2;
    e = cyc + 1;
    exp_start.push_back(use_err ? e + 1 : e + 34 + (10 - s.len()));
    result = value;
    error  = use_err;
    done   = !use_err || also_done;
    @(posedge clk); #2;
    checkOutput("busy_after_capture", int'(busy), 1);
    result = $urandom;
  endtask

  task automatic waitSent(input int budget);
    int start_cnt, n;
    start_cnt = sent_cnt;
    n = 0;
    while (sent_cnt == start_cnt && n < budget) begin
      @(posedge clk);
      n++;
    end
    #2;
    checkOutput("sent_within_budget", int'(sent_cnt != start_cnt), 1);
  endtask

  task automatic dropLines();
    @(posedge clk); #2;
    done  = 1'b0;
    error = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_tx", int'(tx), 1);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_sent", int'(sent), 0);
    rst = 1'b0;
    @(posedge clk); #2;

    applyStimulus(32'd31875000, 1'b0, 1'b0); waitSent(1000); dropLines();
    applyStimulus(32'd0, 1'b0, 1'b0);        waitSent(1000); dropLines();
    applyStimulus(32'hFFFFFFFF, 1'b0, 1'b0); waitSent(1000); dropLines();
    applyStimulus(32'd1234, 1'b1, 1'b1);     waitSent(1000); dropLines();

    // Held done plus extra rises of done and error while busy: one message only.
    applyStimulus(32'd987654, 1'b0, 1'b0);
    repeat (60) @(posedge clk);
    #2; done = 1'b0;
    @(posedge clk); #2; done = 1'b1;
    @(posedge clk); #2; error = 1'b1;
    @(posedge clk); #2; error = 1'b0;
    waitSent(1000);
    repeat (80) @(posedge clk);
    #2;
    checkOutput("idle_tx_after_sent", int'(tx), 1);
    checkOutput("idle_busy_after_sent", int'(busy), 0);
    dropLines();

    // Reset in the middle of the third character, then a clean message.
    applyStimulus(32'd12345678, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (msg_bytes < 2 && n < 1000) begin
        @(posedge clk);
        n++;
      end
      checkOutput("third_char_reached", int'(msg_bytes >= 2), 1);
    end
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    exp_bytes.delete();
    exp_len.delete();
    exp_start.delete();
    #1;
    checkOutput("abort_tx", int'(tx), 1);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_sent", int'(sent), 0);
    done = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    applyStimulus(32'd4096, 1'b0, 1'b0); waitSent(1000); dropLines();

    for (int r = 0; r < 12; r++) begin
      logic [31:0] v;
      bit          use_err;
      v       = $urandom >> $urandom_range(0, 31);
      use_err = ($urandom_range(0, 5) == 0);
      applyStimulus(v, use_err, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat (10) @(posedge clk);
        #2; done = 1'b0; error = 1'b0;
        @(posedge clk); #2; done = 1'b1;
        @(posedge clk); #2; done = 1'b0;
      end
      waitSent(1000);
      dropLines();
    end

    repeat (20) @(posedge clk);
    #2;
    checkOutput("queues_drained", exp_bytes.size() + exp_len.size() + exp_start.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/euler_result_tx.md
# euler_result_tx

Reporting back-end for the Project Euler solver cores. It sits on the solver's `result`/`done`/`error` outputs and captures the answer when the solver finishes. It then converts the answer to unsigned decimal ASCII and transmits it as an 8N1 UART line, so a finished core can be read on a serial terminal instead of in a simulator console. One instance serves one solver core.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Legal range is ≥ 2.
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `result`  in  32: solver answer, unsigned. Sampled only at capture.
- `done`  in  1: solver completion level.
- `error`  in  1: solver failure level.
- `tx`  out  1: UART serial output. Idle high.
- `busy`  out  1: high from the capture edge until the message is fully sent.
- `sent`  out  1: one-cycle pulse after the last stop bit of a message.

## Operation
- Reset values: `tx`=1, `busy`=0, `sent`=0. State is IDLE. The edge-detect registers `done_q`/`error_q` reset to 0.
- Edge detect: the block registers `done_q<=done` and `error_q<=error` every cycle. A rising event is `x & ~x_q` at a clock edge.
- IDLE → CAPTURE:
  - A rising `error` selects the error message "ERR\r\n".
  - Otherwise a rising `done` latches `result` and selects the number message.
  - If both rise at the same edge, error wins.
- Levels held high do not retrigger.
- Rising events while `busy`=1 are discarded, not queued. `done_q`/`error_q` still track, so a level that is still high after the message ends is not a new event.
- CONVERT: double-dabble on a 32-bit shift register plus a 40-bit BCD register (10 digits). The sequence per cycle is: add 3 to every digit ≥5, then shift. It runs exactly 32 cycles.
- SKIP: the digit pointer starts at the most significant digit. It advances one digit per cycle past leading zeros. It stops at the first nonzero digit, or at the last digit, so value 0 prints "0".
- LOAD/START/DATA/STOP: the UART shifter. Each character is `8'h30+digit`, or the fixed error characters.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly `CLKS_PER_BIT` cycles.
  - After the digits, the block sends 0x0D then 0x0A.
- FINISH: `sent`=1 for one cycle, `busy`=0, return to IDLE.
- Error path: skips CONVERT/SKIP and goes directly to LOAD with 'E'.
- Reset mid-operation aborts immediately. `tx` returns high asynchronously and no partial character is completed.

## Timing
- Capture edge E: `busy` is 1 after E. `result` may change from E+1 on with no effect.
- Number path:
  - CONVERT occupies edges E+1..E+32.
  - SKIP takes k cycles, where k = number of leading zeros, 0..9.
  - The first start bit's falling `tx` occurs at edge E+34+k.
- Error path: the first start bit falls at edge E+1.
- Characters are back-to-back. The next start bit begins on the cycle immediately after the previous stop bit's last cycle, with no idle gap.
- Message length is N characters: digits+2, or 5 for "ERR\r\n". `tx` is non-idle for N·10·`CLKS_PER_BIT` cycles.
- `sent` is high in the cycle after the final stop bit ends. `busy` falls on that same edge.
- A new capture can occur at the edge after `sent`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4. A bench UART receiver samples at mid-bit, checks every stop bit is 1, and checks the bit width is exactly 4 cycles.
- `result`=31875000, `done` rises → bytes 0x33 0x31 0x38 0x37 0x35 0x30 0x30 0x30 0x0D 0x0A. The first start bit is at E+36. `sent` pulses once, exactly 400 cycles after the first start bit.
- `result`=0 → "0\r\n" (0x30 0x0D 0x0A). `result`=32'hFFFFFFFF → "4294967295\r\n", 12 bytes with no leading-zero skip.
- `error` rises (and `done` in the same cycle) → "ERR\r\n" (0x45 0x52 0x52 0x0D 0x0A). The first start bit is at E+1.
- `done` held high across the whole message, plus an extra `done` pulse while `busy` → exactly one message. `tx` stays high after `sent`.
- Assert `rst` during the third character → `tx`=1, `busy`=0, `sent`=0 immediately. After release, a new `done` rise produces a complete, correct message.
